uncache_wbuf: RTL and testbench

//  Uncached MMIO access unit between the MEM stage and the AXI bridge. Successor to the single-slot uncache unit.

---
 rtl/uncache_wbuf_pkg.sv | 17 +
 rtl/uncache_wbuf_fifo.sv | 77 +++++++
 rtl/uncache_wbuf.sv | 160 ++++++++++++++++
 tb/tb_uncache_wbuf.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncache_wbuf_pkg.sv
// Shared types and helpers for the uncached MMIO write-buffer unit.
package uncache_wbuf_pkg;

  // One-hot read-sequencing states
  typedef enum logic [3:0] {
    UC_IDLE  = 4'b0001,
    UC_DRAIN = 4'b0010,
    UC_RD    = 4'b0100,
    UC_DONE  = 4'b1000
  } uc_state_e;

  // A buffered write entry packs {addr, strobes, data}
  function automatic int wbEntryWidth(input int aw, input int dw);
    return aw + dw / 8 + dw;
  endfunction

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// Posted-write FIFO: storage, wrapping pointers, occupancy count, head and
// youngest-entry views. The youngest-entry port exists only when
// UNCACHE_RAW_FWD_EN is defined.
module uncache_wbuf_fifo
  import uncache_wbuf_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_push,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW/8-1:0] i_strb,
  input  logic [DW-1:0]   i_data,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_empty,
  output logic [AW-1:0]   o_head_addr,
  output logic [DW/8-1:0] o_head_strb,
`ifdef UNCACHE_RAW_FWD_EN
  output logic [AW-1:0]   o_young_addr,
  output logic [DW/8-1:0] o_young_strb,
  output logic [DW-1:0]   o_young_data,
`endif
  output logic [DW-1:0]   o_head_data
);

  localparam int EW = wbEntryWidth(AW, DW);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);

  logic [EW-1:0] r_mem [WB_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(WB_DEPTH));
  assign o_empty = (r_count == '0);
  // A pop against an empty buffer is dropped so the count never underflows
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign {o_head_addr, o_head_strb, o_head_data} = r_mem[r_rptr];

`ifdef UNCACHE_RAW_FWD_EN
  logic [PW-1:0] w_young_ptr;
  assign w_young_ptr = r_wptr - PW'(1);
  assign {o_young_addr, o_young_strb, o_young_data} = r_mem[w_young_ptr];
`endif

  // Entry storage is not reset; consumers gate it with the empty flag
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_addr, i_strb, i_data};
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached MMIO access unit: posted writes drain through a FIFO in order,
// reads wait for every older write and then go to the bus. Optional
// store-to-load forwarding from the youngest entry under UNCACHE_RAW_FWD_EN.
module uncache_wbuf
  import uncache_wbuf_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            stallreq,
  input  logic            conf_en,
  input  logic [DW/8-1:0] conf_wen,
  input  logic [AW-1:0]   conf_addr,
  input  logic [DW-1:0]   conf_wdata,
  output logic [DW-1:0]   conf_rdata,
  output logic            rd_req,
  output logic [AW-1:0]   rd_addr,
  input  logic            rd_reload,
  input  logic [DW-1:0]   rd_data,
  output logic            wr_req,
  output logic [DW/8-1:0] wr_wstrb,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  input  logic            wr_reload
);

  uc_state_e       r_state;
  uc_state_e       w_next;
  logic [DW-1:0]   r_conf_rdata;
  logic            r_rd_req;
  logic [AW-1:0]   r_rd_addr;
  logic            w_is_read;
  logic            w_is_write;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_head_addr;
  logic [DW/8-1:0] w_head_strb;
  logic [DW-1:0]   w_head_data;
`ifdef UNCACHE_RAW_FWD_EN
  logic [AW-1:0]   w_young_addr;
  logic [DW/8-1:0] w_young_strb;
  logic [DW-1:0]   w_young_data;
  logic            w_fwd_hit;
`endif

  assign w_is_read  = conf_en & ~|conf_wen;
  assign w_is_write = conf_en & |conf_wen;
  // Writes only enter from IDLE; other states already hold the stage
  assign w_push     = (r_state == UC_IDLE) & w_is_write & ~w_full;

`ifdef UNCACHE_RAW_FWD_EN
  // Forward only a full-width match against a live youngest entry
  assign w_fwd_hit = w_is_read & ~w_empty & (w_young_addr == conf_addr) & (&w_young_strb);
`endif

  uncache_wbuf_fifo #(
    .AW       (AW),
    .DW       (DW),
    .WB_DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .i_push       (w_push),
    .i_addr       (conf_addr),
    .i_strb       (conf_wen),
    .i_data       (conf_wdata),
    .i_pop        (wr_reload),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_strb  (w_head_strb),
`ifdef UNCACHE_RAW_FWD_EN
    .o_young_addr (w_young_addr),
    .o_young_strb (w_young_strb),
    .o_young_data (w_young_data),
`endif
    .o_head_data  (w_head_data)
  );

  // Head entry is masked while empty so stale storage never reaches the bus
  assign wr_req     = ~w_empty;
  assign wr_addr    = w_empty ? '0 : w_head_addr;
  assign wr_wstrb   = w_empty ? '0 : w_head_strb;
  assign wr_data    = w_empty ? '0 : w_head_data;
  assign conf_rdata = r_conf_rdata;
  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= UC_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic for read sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      UC_IDLE: begin
        if (w_is_read) begin
`ifdef UNCACHE_RAW_FWD_EN
          w_next = w_fwd_hit ? UC_DONE : UC_DRAIN;
`else
          w_next = UC_DRAIN;
`endif
        end
      end
      UC_DRAIN: if (w_empty) w_next = UC_RD;
      UC_RD:    if (rd_reload) w_next = UC_DONE;
      UC_DONE:  w_next = UC_IDLE;
      default:  w_next = UC_IDLE;
    endcase
  end

  // Stall: reads hold until DONE, writes hold only while the buffer is full
  always_comb begin
    stallreq = 1'b0;
    case (r_state)
      UC_IDLE:  stallreq = w_is_read | (w_is_write & w_full);
      UC_DRAIN: stallreq = 1'b1;
      UC_RD:    stallreq = 1'b1;
      UC_DONE:  stallreq = 1'b0;
      default:  stallreq = 1'b0;
    endcase
  end

  // Registered bus-read request and returned read data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_conf_rdata <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
    end else begin
      case (r_state)
`ifdef UNCACHE_RAW_FWD_EN
        UC_IDLE: if (w_fwd_hit) r_conf_rdata <= w_young_data;
`endif
        UC_DRAIN: begin
          if (w_empty) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= conf_addr;
          end
        end
        UC_RD: begin
          if (rd_reload) begin
            r_conf_rdata <= rd_data;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uncache_wbuf.sv
// Scoreboard bench for uncache_wbuf: stimulus pushes expected bus writes and
// read data into queues, a monitor pops and compares when the DUT presents them.
module tb_uncache_wbuf;

  logic        clk;
  logic        resetn;
  logic        stallreq;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_reload;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_reload;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t         expWr[$];
  logic [31:0] expRd[$];
  int          total = 0;
  int          bad   = 0;
  bit          autoWr = 0;
  bit          autoRd = 0;
  int          popReq = 0;
  int          popsDone = 0;
  int          spurReq = 0;
  int          spurDone = 0;

  uncache_wbuf #(.AW(32), .DW(32), .WB_DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .stallreq   (stallreq),
    .conf_en    (conf_en),
    .conf_wen   (conf_wen),
    .conf_addr  (conf_addr),
    .conf_wdata (conf_wdata),
    .conf_rdata (conf_rdata),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_reload  (rd_reload),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_wstrb   (wr_wstrb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_reload  (wr_reload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Bus responder: auto or counted manual write pops, auto read replies, spurious read pulses
  initial begin
    wr_reload = 1'b0;
    rd_reload = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      wr_reload = 1'b0;
      rd_reload = 1'b0;
      if (resetn) begin
        if (wr_req && autoWr) wr_reload = 1'b1;
        else if (wr_req && popsDone < popReq) begin
          wr_reload = 1'b1;
          popsDone++;
        end
        if (rd_req) rd_reload = autoRd;
        else if (spurDone < spurReq) begin
          rd_reload = 1'b1;
          spurDone++;
        end
      end
    end
  end

  // Monitor: compares completed bus writes and accepted reads against the queues
  initial begin
    wr_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        if (wr_req && wr_reload) begin
          if (expWr.size() == 0) checkOutput("unexpected_bus_write", 32'd1, 32'd0);
          else begin
            e = expWr.pop_front();
            checkOutput("bus_wr_addr", wr_addr, e.addr);
            checkOutput("bus_wr_strb", {28'd0, wr_wstrb}, {28'd0, e.strb});
            checkOutput("bus_wr_data", wr_data, e.data);
          end
        end
        if (conf_en && conf_wen == 4'd0 && !stallreq) begin
          if (expRd.size() == 0) checkOutput("unexpected_read_accept", 32'd1, 32'd0);
          else begin
            r = expRd.pop_front();
            checkOutput("conf_rdata", conf_rdata, r);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    conf_en    = en;
    conf_wen   = wen;
    conf_addr  = addr;
    conf_wdata = data;
  endtask

  // Called at the negedge where the access was applied; returns at the accept sample point
  task automatic waitAccept(input int maxCyc, output int stalls, output bit sawRdReq, output logic [31:0] seenAddr);
    stalls   = 0;
    sawRdReq = 1'b0;
    seenAddr = 32'd0;
    for (int i = 0; i < maxCyc; i++) begin
      #2;
      if (rd_req) begin
        sawRdReq = 1'b1;
        seenAddr = rd_addr;
      end
      if (!stallreq) return;
      stalls++;
      @(negedge clk);
    end
    checkOutput("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic writeOne(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data, output int stalls);
    bit saw;
    logic [31:0] seen;
    applyStimulus(1'b1, strb, addr, data);
    expWr.push_back('{addr, strb, data});
    waitAccept(20, stalls, saw, seen);
  endtask

  task automatic waitEmpty();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (!wr_req) return;
    end
    checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stallreq"}, {31'd0, stallreq}, 32'd0);
    checkOutput({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 32'd0);
    checkOutput({tag, "_conf_rdata"}, conf_rdata, 32'd0);
    checkOutput({tag, "_wr_req"}, {31'd0, wr_req}, 32'd0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 32'd0);
    checkOutput({tag, "_wr_wstrb"}, {28'd0, wr_wstrb}, 32'd0);
    checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
  endtask

  initial begin
    int st;
    bit saw;
    logic [31:0] seen;
    resetn = 1'b0; conf_en = 1'b0; conf_wen = 4'd0; conf_addr = 32'd0;
    conf_wdata = 32'd0; rd_data = 32'd0;
    repeat (2) @(negedge clk);
    #2;
    checkAllZero("por");
    @(negedge clk);
    resetn = 1'b1;

    // Single read, empty buffer, one-cycle bus: stall 1,1,1 then accept
    autoRd = 1'b1; rd_data = 32'h1234_5678;
    applyStimulus(1'b1, 4'd0, 32'hBFAF_0010, 32'd0);
    expRd.push_back(32'h1234_5678);
    waitAccept(20, st, saw, seen);
    checkOutput("rd_stall_cycles", st, 32'd3);
    checkOutput("rd_bus_addr", seen, 32'hBFAF_0010);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    rd_data = 32'hDEAD_BEEF;
    spurReq++;
    #2;
    checkOutput("spurious_pulse_seen", {31'd0, rd_reload}, 32'd1);
    @(negedge clk);
    #2;
    checkOutput("rdata_after_spurious", conf_rdata, 32'h1234_5678);

    // Read ordered behind an older buffered write
    autoWr = 1'b0; rd_data = 32'h0000_0055;
    writeOne(32'hBFAF_8000, 4'hF, 32'h0000_0011, st);
    checkOutput("ord_wr_stall", st, 32'd0);
    applyStimulus(1'b1, 4'd0, 32'hBFAF_8004, 32'd0);
    expRd.push_back(32'h0000_0055);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("ord_rd_req_held", {31'd0, rd_req}, 32'd0);
      @(negedge clk);
    end
    popReq++;
    waitAccept(20, st, saw, seen);
    checkOutput("ord_rd_issued", {31'd0, saw}, 32'd1);
    checkOutput("ord_rd_addr", seen, 32'hBFAF_8004);

    // Fill to full, fifth write stalls, one pop lets it in the cycle after
    for (int i = 0; i < 4; i++) begin
      writeOne(32'h1000_0000 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), st);
      checkOutput("fill_no_stall", st, 32'd0);
    end
    applyStimulus(1'b1, 4'hC, 32'h1000_0010, 32'hA000_0004);
    expWr.push_back('{32'h1000_0010, 4'hC, 32'hA000_0004});
    #2;
    checkOutput("full_stall", {31'd0, stallreq}, 32'd1);
    @(negedge clk);
    popReq++;
    #2;
    checkOutput("full_stall_during_pop", {31'd0, stallreq}, 32'd1);
    @(negedge clk);
    #2;
    checkOutput("fifth_accepted", {31'd0, stallreq}, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    autoWr = 1'b1;
    waitEmpty();

    // Push and pop together at count 2
    autoWr = 1'b0;
    writeOne(32'h2000_0000, 4'h1, 32'h0000_00B0, st);
    writeOne(32'h2000_0004, 4'h2, 32'h0000_B100, st);
    applyStimulus(1'b1, 4'h4, 32'h2000_0008, 32'h00B2_0000);
    popReq++;
    expWr.push_back('{32'h2000_0008, 4'h4, 32'h00B2_0000});
    waitAccept(20, st, saw, seen);
    checkOutput("pushpop_no_stall", st, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("pushpop_count", {29'd0, dut.u_fifo.r_count}, 32'd2);
    checkOutput("pushpop_head_addr", wr_addr, 32'h2000_0004);
    autoWr = 1'b1;
    waitEmpty();

    // Nine writes with continuous drain exercise pointer wrap
    for (int i = 0; i < 9; i++) begin
      writeOne(32'h3000_0100 + 32'(i * 8), 4'(1 << (i % 4)) | 4'(i % 2 == 0 ? 4'h8 : 4'h0),
               32'hC0DE_0000 + 32'(i * 17), st);
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    waitEmpty();

`ifdef UNCACHE_RAW_FWD_EN
    // Full-strobe match forwards from the youngest entry without a bus read
    autoWr = 1'b0; rd_data = 32'h0;
    writeOne(32'h1FAF_FFF0, 4'hF, 32'hA5A5_A5A5, st);
    applyStimulus(1'b1, 4'd0, 32'h1FAF_FFF0, 32'd0);
    expRd.push_back(32'hA5A5_A5A5);
    waitAccept(10, st, saw, seen);
    checkOutput("fwd_stall_cycles", st, 32'd1);
    checkOutput("fwd_no_bus_read", {31'd0, saw}, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("fwd_wbuf_kept", {31'd0, wr_req}, 32'd1);
    autoWr = 1'b1;
    waitEmpty();
`endif

    // Partial-strobe write to the same address takes the normal drain path
    autoWr = 1'b0; autoRd = 1'b1; rd_data = 32'h0000_0077;
    writeOne(32'h1FAF_FFF0, 4'h3, 32'h0000_BEEF, st);
    applyStimulus(1'b1, 4'd0, 32'h1FAF_FFF0, 32'd0);
    expRd.push_back(32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("partial_rd_req_held", {31'd0, rd_req}, 32'd0);
      @(negedge clk);
    end
    popReq++;
    waitAccept(20, st, saw, seen);
    checkOutput("partial_bus_read", {31'd0, saw}, 32'd1);

    // Reset during DRAIN with two buffered writes
    autoWr = 1'b0;
    writeOne(32'h4000_0000, 4'hF, 32'h1111_1111, st);
    writeOne(32'h4000_0004, 4'hF, 32'h2222_2222, st);
    applyStimulus(1'b1, 4'd0, 32'h4000_0008, 32'd0);
    #2;
    checkOutput("drain_stall", {31'd0, stallreq}, 32'd1);
    @(negedge clk);
    resetn = 1'b0; conf_en = 1'b0; conf_wen = 4'd0;
    expWr.delete();
    @(negedge clk);
    #2;
    checkAllZero("rst_drain");
    @(negedge clk);
    resetn = 1'b1;

    // Reset during RD with the bus withholding its reply
    autoRd = 1'b0;
    applyStimulus(1'b1, 4'd0, 32'h5000_0040, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("rd_req_pending", {31'd0, rd_req}, 32'd1);
    checkOutput("rd_addr_pending", rd_addr, 32'h5000_0040);
    @(negedge clk);
    resetn = 1'b0; conf_en = 1'b0; conf_wen = 4'd0;
    @(negedge clk);
    #2;
    checkAllZero("rst_rd");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("exp_writes_left", expWr.size(), 32'd0);
    checkOutput("exp_reads_left", expRd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

endmodule
